// File: rtl/mesh_terminal_ni_if.sv
// mesh_terminal_ni_if: host and router handshake bundle of one mesh terminal network interface.
interface mesh_terminal_ni_if #(
    parameter int pkg_sz = 40
);
    logic [pkg_sz-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [pkg_sz-1:0] data_out_i_in;
    logic              pndng_i_in;
    logic              popin;
    logic [pkg_sz-1:0] data_out;
    logic              pndng;
    logic              pop;
    logic [pkg_sz-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              popin_err;
    logic              misroute;
    logic [7:0]        misroute_cnt;
    modport master (
        output tx_data, tx_valid, popin, data_out, pndng, rx_ready,
        input  tx_ready, data_out_i_in, pndng_i_in, pop, rx_data, rx_valid, popin_err, misroute, misroute_cnt
    );
    modport slave (
        input  tx_data, tx_valid, popin, data_out, pndng, rx_ready,
        output tx_ready, data_out_i_in, pndng_i_in, pop, rx_data, rx_valid, popin_err, misroute, misroute_cnt
    );
endinterface

// File: rtl/mesh_terminal_ni.sv
// mesh_terminal_ni: TX/RX FWFT buffering between a host and one mesh router terminal port.
// Destination checking of received packets is enabled by defining MESH_NI_DEST_CHECK_EN.
module mesh_terminal_ni_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic         rd,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wptr_q] = wdata;
        wptr_d  = wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    assign rdata = mem_q[rptr_q];
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
endmodule

module mesh_terminal_ni #(
    parameter int ROWS       = 4,
    parameter int COLUMNS    = 4,
    parameter int pkg_sz     = 40,
    parameter int fifo_depth = 4,
    parameter int ID_ROW     = 0,
    parameter int ID_COL     = 0
) (
    input logic              clk,
    input logic              reset,
    mesh_terminal_ni_if.slave bus
);
    logic tx_full, tx_empty, rx_full, rx_empty, tx_wr, tx_rd, rx_wr, rx_rd;
    logic popin_err_q, popin_err_d;
    logic [15:0] unused_cfg;
    assign unused_cfg = {4'(ROWS), 4'(COLUMNS), 4'(ID_ROW), 4'(ID_COL)};
    // Handshakes look only at registered counts, so a slot freed this cycle is reusable next cycle.
    assign tx_wr = bus.tx_valid && !tx_full && !reset;
    assign tx_rd = bus.popin && !tx_empty && !reset;
    assign rx_wr = bus.pndng && !rx_full && !reset;
    assign rx_rd = bus.rx_ready && !rx_empty && !reset;
    mesh_terminal_ni_fifo #(.W(pkg_sz), .DEPTH(fifo_depth)) u_tx (
        .clk(clk), .reset(reset), .wr(tx_wr), .rd(tx_rd), .wdata(bus.tx_data),
        .rdata(bus.data_out_i_in), .full(tx_full), .empty(tx_empty)
    );
    mesh_terminal_ni_fifo #(.W(pkg_sz), .DEPTH(fifo_depth)) u_rx (
        .clk(clk), .reset(reset), .wr(rx_wr), .rd(rx_rd), .wdata(bus.data_out),
        .rdata(bus.rx_data), .full(rx_full), .empty(rx_empty)
    );
    assign bus.tx_ready   = !tx_full;
    assign bus.pndng_i_in = !tx_empty;
    assign bus.pop        = rx_wr;
    assign bus.rx_valid   = !rx_empty;
    always_comb popin_err_d = popin_err_q | (bus.popin & tx_empty);
    always_ff @(posedge clk) popin_err_q <= reset ? 1'b0 : popin_err_d;
    assign bus.popin_err = popin_err_q;
`ifdef MESH_NI_DEST_CHECK_EN
    logic       wrong_dest, misroute_q, misroute_d;
    logic [7:0] misroute_cnt_q, misroute_cnt_d;
    always_comb begin
        wrong_dest     = bus.data_out[pkg_sz-9 -: 4] != 4'(ID_ROW) || bus.data_out[pkg_sz-13 -: 4] != 4'(ID_COL);
        misroute_d     = misroute_q | (rx_wr & wrong_dest);
        misroute_cnt_d = (rx_wr && wrong_dest && misroute_cnt_q != 8'hff) ? misroute_cnt_q + 8'd1 : misroute_cnt_q;
    end
    always_ff @(posedge clk) begin
        misroute_q     <= reset ? 1'b0 : misroute_d;
        misroute_cnt_q <= reset ? 8'd0 : misroute_cnt_d;
    end
    assign bus.misroute     = misroute_q;
    assign bus.misroute_cnt = misroute_cnt_q;
`else
    assign bus.misroute     = 1'b0;
    assign bus.misroute_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_mesh_terminal_ni.sv
// tb_mesh_terminal_ni: directed checks of TX/RX buffering, error flags and reset of mesh_terminal_ni.
module tb_mesh_terminal_ni;
`ifdef MESH_NI_DEST_CHECK_EN
    localparam bit DCHK = 1'b1;
`else
    localparam bit DCHK = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [39:0] rxp [6];
    mesh_terminal_ni_if #(.pkg_sz(40)) bus ();
    mesh_terminal_ni #(.ROWS(4), .COLUMNS(4), .pkg_sz(40), .fifo_depth(4), .ID_ROW(1), .ID_COL(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [39:0] mk(input logic [3:0] r, input logic [3:0] c, input logic [23:0] p);
        return {8'hA5, r, c, p};
    endfunction
    initial begin
        int idx, got, n;
        logic p;
        logic [39:0] badp, goodp;
        bus.tx_data = '0; bus.tx_valid = 0; bus.popin = 0;
        bus.data_out = '0; bus.pndng = 0; bus.rx_ready = 0;
        tick; tick;
        reset = 0;
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_pndng_i_in", bus.pndng_i_in, 0);
        chk("rst_pop", bus.pop, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_popin_err", bus.popin_err, 0);
        chk("rst_misroute", bus.misroute, 0);
        chk("rst_misroute_cnt", bus.misroute_cnt, 0);
        // TX fill and drain
        for (int i = 0; i < 4; i++) begin
            bus.tx_data = mk(4'(i), 4'(i), 24'(i + 1)); bus.tx_valid = 1;
            tick;
            chk("tx_fill_pndng", bus.pndng_i_in, 1);
        end
        bus.tx_valid = 0;
        chk("tx_full_ready", bus.tx_ready, 0);
        chk("tx_full_head", bus.data_out_i_in, mk(0, 0, 1));
        bus.popin = 1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_drain_head", bus.data_out_i_in, mk(4'(i), 4'(i), 24'(i + 1)));
            tick;
        end
        bus.popin = 0;
        chk("tx_drained_pndng", bus.pndng_i_in, 0);
        chk("tx_drained_ready", bus.tx_ready, 1);
        chk("tx_no_popin_err", bus.popin_err, 0);
        // TX full with simultaneous write attempt and pop
        for (int i = 0; i < 4; i++) begin
            bus.tx_data = mk(4'hA, 4'hB, 24'(16 + i)); bus.tx_valid = 1;
            tick;
        end
        bus.tx_data = mk(4'hE, 4'hE, 24'hEEEE); bus.popin = 1;
        tick;
        bus.tx_valid = 0; bus.popin = 0;
        chk("tx_simul_ready", bus.tx_ready, 1);
        chk("tx_simul_head", bus.data_out_i_in, mk(4'hA, 4'hB, 17));
        bus.popin = 1;
        for (int i = 1; i < 4; i++) begin
            chk("tx_simul_order", bus.data_out_i_in, mk(4'hA, 4'hB, 24'(16 + i)));
            tick;
        end
        bus.popin = 0;
        chk("tx_simul_no_dup", bus.pndng_i_in, 0);
        // RX backpressure
        for (int i = 0; i < 6; i++) rxp[i] = mk(1, 2, 24'(24'h100 + i));
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bus.data_out = rxp[idx]; bus.pndng = 1;
            #1;
            chk("rx_bp_pop", bus.pop, (c < 4) ? 1 : 0);
            p = bus.pop;
            tick;
            if (p) idx++;
        end
        bus.rx_ready = 1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (bus.rx_valid) begin
                chk("rx_order", bus.rx_data, rxp[got]);
                got++;
            end
            bus.pndng = idx < 6;
            bus.data_out = rxp[(idx < 6) ? idx : 0];
            #1;
            p = bus.pop;
            tick;
            if (p) idx++;
        end
        chk("rx_all_popped", idx, 6);
        chk("rx_all_got", got, 6);
        bus.pndng = 0; bus.rx_ready = 0;
        chk("rx_empty_after", bus.rx_valid, 0);
        // popin while TX empty
        bus.popin = 1;
        tick;
        bus.popin = 0;
        chk("popin_err_set", bus.popin_err, 1);
        chk("popin_err_cnt0", bus.pndng_i_in, 0);
        tick;
        chk("popin_err_sticky", bus.popin_err, 1);
        // destination check: first a correctly addressed packet, then misrouted ones
        goodp = mk(1, 2, 24'h00600D);
        badp = mk(3, 2, 24'h000BAD);
        bus.data_out = goodp; bus.pndng = 1;
        tick;
        bus.pndng = 0;
        chk("good_rx_data", bus.rx_data, goodp);
        chk("good_misroute", bus.misroute, 0);
        chk("good_misroute_cnt", bus.misroute_cnt, 0);
        bus.rx_ready = 1;
        tick;
        bus.rx_ready = 0;
        bus.data_out = badp; bus.pndng = 1;
        tick;
        bus.pndng = 0;
        chk("bad_rx_data", bus.rx_data, badp);
        chk("bad_misroute", bus.misroute, DCHK);
        chk("bad_misroute_cnt", bus.misroute_cnt, DCHK ? 1 : 0);
        bus.pndng = 1; bus.rx_ready = 1;
        n = 0;
        for (int c = 0; c < 400 && n < 299; c++) begin
            #1;
            if (bus.pop) n++;
            tick;
        end
        bus.pndng = 0;
        chk("sat_sent", n, 299);
        tick; tick;
        bus.rx_ready = 0;
        chk("sat_rx_drained", bus.rx_valid, 0);
        chk("sat_misroute_cnt", bus.misroute_cnt, DCHK ? 255 : 0);
        chk("sat_misroute", bus.misroute, DCHK);
        // reset mid-traffic: 2 TX and 3 RX entries buffered
        bus.tx_valid = 1; bus.pndng = 1; bus.data_out = goodp; bus.tx_data = mk(5, 5, 5);
        tick; tick;
        bus.tx_valid = 0;
        tick;
        bus.pndng = 0;
        chk("pre_rst_pndng_i_in", bus.pndng_i_in, 1);
        chk("pre_rst_rx_valid", bus.rx_valid, 1);
        bus.popin = 1; bus.tx_valid = 1; bus.pndng = 1; bus.rx_ready = 1; reset = 1;
        #1;
        chk("mid_rst_pop", bus.pop, 0);
        tick;
        bus.popin = 0; bus.tx_valid = 0; bus.pndng = 0; bus.rx_ready = 0;
        chk("mid_rst_pndng_i_in", bus.pndng_i_in, 0);
        chk("mid_rst_rx_valid", bus.rx_valid, 0);
        chk("mid_rst_tx_ready", bus.tx_ready, 1);
        chk("mid_rst_popin_err", bus.popin_err, 0);
        chk("mid_rst_misroute_cnt", bus.misroute_cnt, 0);
        reset = 0;
        tick;
        chk("post_rst_pndng_i_in", bus.pndng_i_in, 0);
        chk("post_rst_rx_valid", bus.rx_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
